signal_phase_scheduler: RTL and testbench

//  Sequences the green phase of a 4-approach intersection (A,B,C,D = index 0..3).

---
 rtl/signal_phase_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_signal_phase_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_phase_scheduler.sv
// rtl/signal_phase_scheduler.sv - green-phase sequencer for a 4-approach intersection
module signal_phase_scheduler #(
  parameter int BASE_GREEN = 4,
  parameter int EXT_GREEN  = 2,
  parameter int YELLOW     = 2,
  parameter int ALL_RED    = 1,
  parameter int MAX_WAIT   = 24,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [11:0]      lane_sense,
  input  logic [3:0]       emerg,
  output logic [11:0]      lamp,
  output logic [1:0]       state,
  output logic [1:0]       grant_id,
  output logic [CNT_W-1:0] green_remaining,
  output logic             preempt_active,
  output logic [3:0]       starve_flag
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_EMERG  = 2'd3
  } phase_e;

  phase_e                  state_q, state_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]        served_q, served_d;
  logic [1:0]              grant_q, grant_d;
  logic [1:0]              last_q, last_d;
  logic [3:0][CNT_W-1:0]   wait_q, wait_d;
  logic [11:0]             lamp_q, lamp_d;
  logic                    preempt_q, preempt_d;
  logic [CNT_W-1:0]        green_rem_q, green_rem_d;
  logic [3:0]              starve_q, starve_d;

  logic [3:0]              dem;
  logic [3:0][1:0]         lvl;
  logic                    emerg_hit, starve_hit, rr_hit;
  logic [1:0]              emerg_k, starve_k, rr_k, sel_k;
  logic [CNT_W-1:0]        green_len;
  logic                    other_emerg;
  logic                    granted;
  logic                    green_now;

  // Per-approach demand and density level straight from the three lane sensors
  always_comb begin
    dem = '0;
    lvl = '0;
    for (int k = 0; k < 4; k++) begin
      dem[k] = |lane_sense[3*k +: 3];
      lvl[k] = {1'b0, lane_sense[3*k]} + {1'b0, lane_sense[3*k+1]} + {1'b0, lane_sense[3*k+2]};
    end
  end

  // Candidate selection: lowest emergency, lowest starved, then round-robin after last
  always_comb begin
    emerg_hit  = |emerg;
    starve_hit = |starve_q;
    emerg_k    = 2'd0;
    starve_k   = 2'd0;
    rr_hit     = 1'b0;
    rr_k       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (emerg[k])    emerg_k  = 2'(k);
      if (starve_q[k]) starve_k = 2'(k);
    end
    for (int i = 4; i >= 1; i--) begin
      if (dem[2'(last_q + 2'(i))]) begin
        rr_hit = 1'b1;
        rr_k   = 2'(last_q + 2'(i));
      end
    end
    sel_k       = emerg_hit ? emerg_k : (starve_hit ? starve_k : rr_k);
    green_len   = CNT_W'(BASE_GREEN) + CNT_W'(EXT_GREEN) * CNT_W'(lvl[sel_k]);
    other_emerg = |(emerg & ~(4'b0001 << grant_q));
  end

  // Phase sequencing: ALLRED selects, GREEN times out or gaps out, EMERG holds, YELLOW clears
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    served_d = served_q;
    grant_d  = grant_q;
    last_d   = last_q;
    granted  = 1'b0;
    unique case (state_q)
      ST_ALLRED: begin
        if (timer_q <= CNT_W'(1)) begin
          if (emerg_hit) begin
            state_d = ST_EMERG;
            grant_d = emerg_k;
            granted = 1'b1;
          end else if (starve_hit || rr_hit) begin
            state_d  = ST_GREEN;
            grant_d  = sel_k;
            last_d   = sel_k;
            timer_d  = green_len;
            served_d = CNT_W'(1);
            granted  = 1'b1;
          end else begin
            timer_d = CNT_W'(1);
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_GREEN: begin
        if (emerg[grant_q]) begin
          state_d = ST_EMERG;
        end else if (other_emerg || (timer_q <= CNT_W'(1)) ||
                     (!dem[grant_q] && (served_q >= CNT_W'(BASE_GREEN)))) begin
          state_d = ST_YELLOW;
          timer_d = CNT_W'(YELLOW);
        end else begin
          timer_d  = timer_q - CNT_W'(1);
          served_d = served_q + CNT_W'(1);
        end
      end
      ST_EMERG: begin
        if (!emerg[grant_q]) begin
          state_d = ST_YELLOW;
          timer_d = CNT_W'(YELLOW);
        end
      end
      ST_YELLOW: begin
        if (timer_q <= CNT_W'(1)) begin
          state_d = ST_ALLRED;
          timer_d = CNT_W'(ALL_RED);
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: state_d = ST_ALLRED;
    endcase
  end

  // Wait counters: count waiting demand while not green, saturate, clear on grant
  always_comb begin
    green_now = (state_q == ST_GREEN) || (state_q == ST_EMERG);
    wait_d    = wait_q;
    starve_d  = '0;
    for (int j = 0; j < 4; j++) begin
      if (granted && (grant_d == 2'(j))) begin
        wait_d[j] = '0;
      end else if (dem[j] && !(green_now && (grant_q == 2'(j))) &&
                   (wait_q[j] < CNT_W'(MAX_WAIT))) begin
        wait_d[j] = wait_q[j] + CNT_W'(1);
      end
      starve_d[j] = (wait_d[j] == CNT_W'(MAX_WAIT));
    end
  end

  // Output decode from the next state so the registered outputs carry no extra latency
  always_comb begin
    lamp_d = 12'h249;
    for (int k = 0; k < 4; k++) begin
      if (((state_d == ST_GREEN) || (state_d == ST_EMERG)) && (grant_d == 2'(k)))
        lamp_d[3*k +: 3] = 3'b100;
      else if ((state_d == ST_YELLOW) && (grant_d == 2'(k)))
        lamp_d[3*k +: 3] = 3'b010;
    end
    preempt_d   = (state_d == ST_EMERG);
    green_rem_d = (state_d == ST_GREEN) ? timer_d : '0;
  end

  // State and output registers; clear forces all red immediately
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_ALLRED;
      timer_q     <= CNT_W'(ALL_RED);
      served_q    <= '0;
      grant_q     <= 2'd0;
      last_q      <= 2'd3;
      wait_q      <= '0;
      lamp_q      <= 12'h249;
      preempt_q   <= 1'b0;
      green_rem_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      served_q    <= served_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      wait_q      <= wait_d;
      lamp_q      <= lamp_d;
      preempt_q   <= preempt_d;
      green_rem_q <= green_rem_d;
      starve_q    <= starve_d;
    end
  end

  assign lamp            = lamp_q;
  assign state           = state_q;
  assign grant_id        = grant_q;
  assign green_remaining = green_rem_q;
  assign preempt_active  = preempt_q;
  assign starve_flag     = starve_q;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// tb/tb_signal_phase_scheduler.sv - randomized and directed bench for signal_phase_scheduler
module tb_signal_phase_scheduler;

  localparam int BASE = 4;
  localparam int EXT  = 2;
  localparam int YEL  = 2;
  localparam int ARD  = 1;
  localparam int MAXW = 8;
  localparam int CW   = 8;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [11:0]   lane_sense = '0;
  logic [3:0]    emerg = '0;
  logic [11:0]   lamp;
  logic [1:0]    state;
  logic [1:0]    grant_id;
  logic [CW-1:0] green_remaining;
  logic          preempt_active;
  logic [3:0]    starve_flag;

  signal_phase_scheduler #(
    .BASE_GREEN(BASE), .EXT_GREEN(EXT), .YELLOW(YEL), .ALL_RED(ARD),
    .MAX_WAIT(MAXW), .CNT_W(CW)
  ) dut (
    .clock(clock), .clear(clear), .lane_sense(lane_sense), .emerg(emerg),
    .lamp(lamp), .state(state), .grant_id(grant_id),
    .green_remaining(green_remaining), .preempt_active(preempt_active),
    .starve_flag(starve_flag)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0=allred 1=green 2=yellow 3=emergency; m_left = cycles left in phase
  int m_phase, m_left, m_served, m_grant, m_last;
  int m_wait [4];

  task automatic model_reset();
    m_phase = 0; m_left = ARD; m_served = 0; m_grant = 0; m_last = 3;
    for (int k = 0; k < 4; k++) m_wait[k] = 0;
  endtask

  function automatic logic [11:0] model_lamp();
    logic [11:0] l;
    l = 12'h249;
    if (m_phase == 1 || m_phase == 3) l[3*m_grant +: 3] = 3'b100;
    else if (m_phase == 2)            l[3*m_grant +: 3] = 3'b010;
    return l;
  endfunction

  function automatic logic [3:0] model_starve();
    logic [3:0] s;
    for (int k = 0; k < 4; k++) s[k] = (m_wait[k] == MAXW);
    return s;
  endfunction

  task automatic model_step(input logic [11:0] ls, input logic [3:0] em);
    int lvl [4];
    int granted, green_k, sel;
    granted = -1;
    sel     = -1;
    for (int k = 0; k < 4; k++) lvl[k] = $countones(ls[3*k +: 3]);
    green_k = (m_phase == 1 || m_phase == 3) ? m_grant : -1;
    if (m_phase == 0) begin
      if (m_left > 1) m_left--;
      else begin
        for (int k = 3; k >= 0; k--) if (em[k]) sel = k;
        if (sel >= 0) begin
          m_phase = 3; m_grant = sel; granted = sel;
        end else begin
          for (int k = 3; k >= 0; k--) if (m_wait[k] == MAXW) sel = k;
          if (sel < 0)
            for (int i = 4; i >= 1; i--) if (lvl[(m_last + i) % 4] > 0) sel = (m_last + i) % 4;
          if (sel >= 0) begin
            m_phase = 1; m_grant = sel; m_last = sel; granted = sel;
            m_left = BASE + EXT * lvl[sel]; m_served = 1;
          end else m_left = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (em[m_grant]) m_phase = 3;
      else if ((em & ~(4'b0001 << m_grant)) != 0 || m_left <= 1 ||
               (lvl[m_grant] == 0 && m_served >= BASE)) begin
        m_phase = 2; m_left = YEL;
      end else begin
        m_left--; m_served++;
      end
    end else if (m_phase == 3) begin
      if (!em[m_grant]) begin m_phase = 2; m_left = YEL; end
    end else begin
      if (m_left <= 1) begin m_phase = 0; m_left = ARD; end
      else m_left--;
    end
    for (int j = 0; j < 4; j++) begin
      if (granted == j) m_wait[j] = 0;
      else if (lvl[j] > 0 && green_k != j && m_wait[j] < MAXW) m_wait[j]++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_lamp"},    32'(lamp),            32'(model_lamp()));
    check({tag, "_state"},   32'(state),           32'(m_phase));
    check({tag, "_grant"},   32'(grant_id),        32'(m_grant));
    check({tag, "_grem"},    32'(green_remaining), (m_phase == 1) ? 32'(m_left) : 32'd0);
    check({tag, "_preempt"}, 32'(preempt_active),  32'(m_phase == 3));
    check({tag, "_starve"},  32'(starve_flag),     32'(model_starve()));
  endtask

  // One cycle per iteration: check at the falling edge, then drive and advance the model
  task automatic run(input int n, input logic [11:0] ls, input logic [3:0] em, input string tag);
    for (int c = 0; c < n; c++) begin
      check_outputs(tag);
      lane_sense = ls;
      emerg      = em;
      model_step(ls, em);
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic reset_mid(input string tag);
    #2 clear = 1'b0;
    #1;
    check({tag, "_lamp"},  32'(lamp),            32'h249);
    check({tag, "_state"}, 32'(state),           32'd0);
    check({tag, "_grem"},  32'(green_remaining), 32'd0);
    check({tag, "_starve"},32'(starve_flag),     32'd0);
    @(negedge clock);
    clear = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [11:0] ls;
    logic [3:0]  em;
    model_reset();
    // T1: reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      lane_sense = 12'($urandom);
      emerg      = 4'($urandom);
      #1;
      check("t1_lamp",    32'(lamp),            32'h249);
      check("t1_state",   32'(state),           32'd0);
      check("t1_starve",  32'(starve_flag),     32'd0);
      check("t1_grem",    32'(green_remaining), 32'd0);
      check("t1_preempt", 32'(preempt_active),  32'd0);
    end
    @(negedge clock);
    clear = 1'b1;
    model_reset();

    // T2: B alone at level 2
    check("t2_c0", 32'(lamp), 32'h249);
    run(1, 12'h018, 4'h0, "t2");
    for (int c = 1; c <= 12; c++) begin
      check("t2_lamp", 32'(lamp),
            (c <= 8 || c == 12) ? 32'h261 : (c <= 10) ? 32'h251 : 32'h249);
      run(1, 12'h018, 4'h0, "t2");
    end
    reset_mid("t2_rst");

    // T3: A and C alternate at level 1
    run(1, 12'h041, 4'h0, "t3");
    check("t3_g1", 32'(grant_id), 32'd0);
    run(9, 12'h041, 4'h0, "t3");
    check("t3_g2", 32'(grant_id), 32'd2);
    check("t3_lampc", 32'(lamp), 32'h309);
    check("t3_len", 32'(green_remaining), 32'd6);
    run(9, 12'h041, 4'h0, "t3");
    check("t3_g3", 32'(grant_id), 32'd0);
    run(9, 12'h041, 4'h0, "t3");
    check("t3_g4", 32'(grant_id), 32'd2);
    reset_mid("t3_rst");

    // T4: gap-out after minimum green
    run(3, 12'h001, 4'h0, "t4");
    run(1, 12'h000, 4'h0, "t4");
    check("t4_still", 32'(state), 32'd1);
    check("t4_grem", 32'(green_remaining), 32'd3);
    run(1, 12'h000, 4'h0, "t4");
    check("t4_yel", 32'(lamp), 32'h24A);
    run(5, 12'h000, 4'h0, "t4");
    check("t4_idle", 32'(state), 32'd0);
    reset_mid("t4_rst");

    // T5: preemption for D during A green
    run(2, 12'h001, 4'h0, "t5");
    run(1, 12'h001, 4'h8, "t5");
    check("t5_yel", 32'(lamp), 32'h24A);
    run(2, 12'h001, 4'h8, "t5");
    check("t5_ar", 32'(lamp), 32'h249);
    run(1, 12'h001, 4'h8, "t5");
    check("t5_em", 32'(state), 32'd3);
    check("t5_pre", 32'(preempt_active), 32'd1);
    check("t5_lamp", 32'(lamp), 32'h849);
    run(3, 12'h001, 4'h8, "t5");
    check("t5_hold", 32'(grant_id), 32'd3);
    run(1, 12'h001, 4'h0, "t5");
    check("t5_dyel", 32'(lamp), 32'h449);
    check("t5_pre0", 32'(preempt_active), 32'd0);
    run(3, 12'h001, 4'h0, "t5");
    reset_mid("t5_rst");

    // T6: starved D beats round-robin choice of B
    run(1, 12'h007, 4'h0, "t6");
    run(7, 12'h207, 4'h0, "t6");
    check("t6_pre", 32'(starve_flag), 32'h0);
    run(1, 12'h207, 4'h0, "t6");
    check("t6_flag", 32'(starve_flag), 32'h8);
    run(5, 12'h20F, 4'h0, "t6");
    check("t6_grant", 32'(grant_id), 32'd3);
    check("t6_state", 32'(state), 32'd1);
    check("t6_clr", 32'(starve_flag), 32'h0);
    reset_mid("t6_rst");

    // Random traffic with occasional emergencies and resets
    ls = 12'($urandom);
    em = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0)
        ls = ($urandom_range(1) == 0) ? 12'($urandom) : 12'($urandom & $urandom & $urandom);
      if (em == 4'h0) begin
        if ($urandom_range(59) == 0) em = 4'($urandom_range(15, 1));
      end else if ($urandom_range(9) == 0) em = 4'h0;
      if ($urandom_range(799) == 0) reset_mid("rnd_rst");
      run(1, ls, em, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
